// File: rtl/ft600_pkg.sv
// ft600_pkg: shared widths, state type and byte-enable constants for the FT600 bridge.
package ft600_pkg;

    localparam int FT600_BEAT_W     = 32;
    localparam int FT600_WORD_W     = 128;
    localparam int FT600_BEATS      = 4;
    localparam int FT600_BEAT_IDX_W = $clog2(FT600_BEATS);

    localparam logic [FT600_BEAT_IDX_W-1:0] FT600_LAST_BEAT = FT600_BEAT_IDX_W'(FT600_BEATS - 1);

    localparam logic [3:0] FT600_BE_ALL  = 4'hF;
    localparam logic [3:0] FT600_BE_NONE = 4'h0;

    typedef enum logic {
        IDLE,
        SEND
    } ft600_tx_state_t;

endpackage

// File: rtl/ft600_tx.sv
// ft600_tx: drains 128-bit words from an upstream FIFO as four 32-bit FT600 beats.
// Optional macro FT600_TX_STATS_EN adds the tx_words completed-word counter.
module ft600_tx
    import ft600_pkg::*;
(
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [FT600_WORD_W-1:0] src_first,
    input  logic                    src_first__RDY,
    input  logic                    src_deq__RDY,
    output logic                    src_deq__ENA,
    input  logic                    usb_txe_n,
    output logic                    usb_wr_n,
    output logic [FT600_BEAT_W-1:0] usb_data,
    output logic [3:0]              usb_be,
    output logic                    usb_data_oe
`ifdef FT600_TX_STATS_EN
    ,
    output logic [31:0]             tx_words
`endif
);

    ft600_tx_state_t                             state;
    logic [FT600_BEATS-1:0][FT600_BEAT_W-1:0]    hold;
    logic [FT600_BEAT_IDX_W-1:0]                 beat;
    logic [FT600_BEAT_IDX_W-1:0]                 beat_nx;
    logic                                        take;
    logic                                        accept;
    logic                                        last_accept;

    always_comb begin
        accept      = (state == SEND) & ~usb_wr_n & ~usb_txe_n;
        last_accept = accept & (beat == FT600_LAST_BEAT);
        take        = src_first__RDY & src_deq__RDY & ((state == IDLE) | last_accept);
        beat_nx     = beat + 1'b1;
    end

    assign src_deq__ENA = take;

    // Bus outputs are registered alongside the state so they always match the beat on the wire.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state       <= IDLE;
            hold        <= '0;
            beat        <= '0;
            usb_wr_n    <= 1'b1;
            usb_data    <= '0;
            usb_be      <= FT600_BE_NONE;
            usb_data_oe <= 1'b0;
        end else if (take) begin
            state       <= SEND;
            hold        <= src_first;
            beat        <= '0;
            usb_wr_n    <= 1'b0;
            usb_data    <= src_first[FT600_BEAT_W-1:0];
            usb_be      <= FT600_BE_ALL;
            usb_data_oe <= 1'b1;
        end else if (last_accept) begin
            state       <= IDLE;
            usb_wr_n    <= 1'b1;
            usb_data    <= '0;
            usb_be      <= FT600_BE_NONE;
            usb_data_oe <= 1'b0;
        end else if (accept) begin
            beat        <= beat_nx;
            usb_data    <= hold[beat_nx];
        end
    end

`ifdef FT600_TX_STATS_EN
    always_ff @(posedge CLK) begin
        if (!nRST)
            tx_words <= '0;
        else if (last_accept)
            tx_words <= tx_words + 32'd1;
    end
`endif

endmodule
